boot_loaded_unified_mem: RTL and testbench

Unified instruction/data word memory that sits directly upstream of the multi-cycle MIPS core. It drives the core's `DATA` input from the core's `Addr`, and it accepts stores when the core raises `MEM_WS`. After reset it holds the core in reset while a byte-serial loader fills memory with a program image. Once the last byte is accepted, it releases the core to fetch from address 0.

---
 rtl/boot_loaded_unified_mem.sv | 130 +++++++++++++
 tb/tb_boot_loaded_unified_mem.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_loaded_unified_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : boot_loaded_unified_mem                                         |
// | Purpose  : Unified I/D word memory filled by a byte-serial boot loader,    |
// |            holding the core in reset until the image is complete.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module boot_loaded_unified_mem #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int DEPTH_LOG2       = 10
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        LD_VALID,
    input  logic [7:0]                  LD_BYTE,
    input  logic                        LD_LAST,
    output logic                        LD_READY,
    output logic                        CPU_RST,
    input  logic [ADDRESS_WIDTH-1:0]    Addr,
    input  logic                        MEM_WS,
    input  logic [INSTR_DATA_WIDTH-1:0] WR_DATA,
    output logic [INSTR_DATA_WIDTH-1:0] DATA,
    output logic [DEPTH_LOG2:0]         WORD_CNT,
    output logic                        ERR
);

    localparam int                  c_depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [0:0]          c_load  = 1'b0;
    localparam logic [0:0]          c_run   = 1'b1;

    logic [0:0]                  r_state;
    logic [0:0]                  w_next_state;
    logic [1:0]                  r_byte_cnt;
    logic [INSTR_DATA_WIDTH-1:0] r_word;
    logic [INSTR_DATA_WIDTH-1:0] w_word;
    logic [DEPTH_LOG2:0]         r_word_cnt;
    logic                        r_err;
    logic [INSTR_DATA_WIDTH-1:0] r_mem [c_depth];
    logic                        w_accept;
    logic                        w_word_due;
    logic                        w_full;
    logic [DEPTH_LOG2-1:0]       w_core_idx;
    logic                        w_unused;

    assign w_accept   = LD_VALID && LD_READY;
    assign w_word_due = w_accept && ((r_byte_cnt == 2'd3) || LD_LAST);
    assign w_full     = (r_word_cnt == c_full);
    assign w_core_idx = Addr[DEPTH_LOG2+1:2];
    assign w_unused   = ^{Addr[ADDRESS_WIDTH-1:DEPTH_LOG2+2], Addr[1:0]};

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_load;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_load:  if (w_accept && LD_LAST) w_next_state = c_run;
            c_run:   w_next_state = c_run;
            default: w_next_state = c_load;
        endcase
    end

    // Output decode of the registered state
    always_comb begin
        LD_READY = 1'b0;
        CPU_RST  = 1'b0;
        if (r_state == c_load) begin
            LD_READY = 1'b1;
            CPU_RST  = 1'b1;
        end
    end

    // Big-endian merge of the incoming byte; a fresh word starts from zero so
    // a short final word has its unfilled low bytes cleared.
    always_comb begin
        w_word = (r_byte_cnt == 2'd0) ? '0 : r_word;
        case (r_byte_cnt)
            2'd0:    w_word[31:24] = LD_BYTE;
            2'd1:    w_word[23:16] = LD_BYTE;
            2'd2:    w_word[15:8]  = LD_BYTE;
            default: w_word[7:0]   = LD_BYTE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_byte_cnt <= 2'd0;
            r_word     <= '0;
            r_word_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_word     <= w_word;
            r_byte_cnt <= LD_LAST ? 2'd0 : r_byte_cnt + 2'd1;
            if (w_word_due) begin
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end
        end
    end

    // Loader and core writes are mutually exclusive by state; the array is
    // never cleared so an image survives a reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (w_word_due && !w_full) begin
                r_mem[r_word_cnt[DEPTH_LOG2-1:0]] <= w_word;
            end else if ((r_state == c_run) && MEM_WS) begin
                r_mem[w_core_idx] <= WR_DATA;
            end
        end
    end

    assign DATA     = r_mem[w_core_idx];
    assign WORD_CNT = r_word_cnt;
    assign ERR      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_boot_loaded_unified_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_boot_loaded_unified_mem                                      |
// | Purpose  : Directed vector bench for boot_loaded_unified_mem.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_boot_loaded_unified_mem;

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  b;
        logic        l;
        logic        ws;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [10:0] cnt;
        logic        rdy;
        logic        crst;
        logic        err;
        logic        chk;
        logic [31:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        cpu_rst;
    logic [31:0] addr = 32'h0;
    logic        mem_ws = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] data;
    logic [10:0] word_cnt;
    logic        err;

    logic        ov_rst = 1'b1;
    logic        ov_valid = 1'b0;
    logic [7:0]  ov_byte = 8'h00;
    logic        ov_last = 1'b0;
    logic        ov_ready;
    logic        ov_cpu_rst;
    logic [31:0] ov_addr = 32'h0;
    logic [31:0] ov_data;
    logic [2:0]  ov_cnt;
    logic        ov_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    boot_loaded_unified_mem #(.ADDRESS_WIDTH(32), .INSTR_DATA_WIDTH(32), .DEPTH_LOG2(10)) u_dut (
        .CLK(clk), .RST(rst), .LD_VALID(ld_valid), .LD_BYTE(ld_byte), .LD_LAST(ld_last),
        .LD_READY(ld_ready), .CPU_RST(cpu_rst), .Addr(addr), .MEM_WS(mem_ws),
        .WR_DATA(wr_data), .DATA(data), .WORD_CNT(word_cnt), .ERR(err)
    );

    boot_loaded_unified_mem #(.ADDRESS_WIDTH(32), .INSTR_DATA_WIDTH(32), .DEPTH_LOG2(2)) u_ovf (
        .CLK(clk), .RST(ov_rst), .LD_VALID(ov_valid), .LD_BYTE(ov_byte), .LD_LAST(ov_last),
        .LD_READY(ov_ready), .CPU_RST(ov_cpu_rst), .Addr(ov_addr), .MEM_WS(1'b0),
        .WR_DATA(32'h0), .DATA(ov_data), .WORD_CNT(ov_cnt), .ERR(ov_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r, v, b, l, ws, input logic [31:0] a, wd,
                                input int cnt, rdy, crst, e, chk, input logic [31:0] d);
        vec_t t;
        t.rst = r[0];   t.v = v[0];     t.b = b[7:0];   t.l = l[0];   t.ws = ws[0];
        t.addr = a;     t.wd = wd;      t.cnt = cnt[10:0];
        t.rdy = rdy[0]; t.crst = crst[0]; t.err = e[0]; t.chk = chk[0]; t.data = d;
        return t;
    endfunction

    vec_t vecs[$];
    logic [7:0] img [8];

    initial begin
        //                     rst v  byte  l ws addr        wdata         cnt rdy crst err chk data
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h20, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h08, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h00, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h05, 0, 0, 32'h0,    32'h0,         1, 1, 1, 0, 1, 32'h20080005));
        vecs.push_back(mk(0, 1, 'h00, 0, 0, 32'h0,    32'h0,         1, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h00, 0, 0, 32'h0,    32'h0,         1, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 'hFF, 1, 0, 32'h0,    32'h0,         1, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h00, 0, 1, 32'h0,    32'hBADBAD00,  1, 1, 1, 0, 1, 32'h20080005));
        vecs.push_back(mk(0, 1, 'h0C, 1, 0, 32'h4,    32'h0,         2, 0, 0, 0, 1, 32'h0000000C));
        vecs.push_back(mk(0, 1, 'h77, 1, 0, 32'h5,    32'h0,         2, 0, 0, 0, 1, 32'h0000000C));
        vecs.push_back(mk(0, 1, 'h55, 0, 0, 32'h1000, 32'h0,         2, 0, 0, 0, 1, 32'h20080005));
        vecs.push_back(mk(0, 0, 'h00, 0, 1, 32'h8,    32'h12345678,  2, 0, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 1, 32'h20080005));
        vecs.push_back(mk(0, 1, 'hE1, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'hE2, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'hE3, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'hE4, 0, 0, 32'h0,    32'h0,         1, 1, 1, 0, 1, 32'hE1E2E3E4));
        vecs.push_back(mk(0, 1, 'hE5, 0, 0, 32'h0,    32'h0,         1, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 'h66, 1, 0, 32'h4,    32'h0,         0, 1, 1, 0, 1, 32'h0000000C));
        vecs.push_back(mk(0, 1, 'h01, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h02, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h03, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h04, 1, 0, 32'h0,    32'h0,         1, 0, 0, 0, 1, 32'h01020304));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 32'h4,    32'h0,         0, 1, 1, 0, 1, 32'h0000000C));
        vecs.push_back(mk(0, 1, 'hAA, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'hBB, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'hCC, 0, 0, 32'h0,    32'h0,         0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'hDD, 0, 0, 32'h0,    32'h0,         1, 1, 1, 0, 1, 32'hAABBCCDD));
        vecs.push_back(mk(0, 1, 'h11, 0, 0, 32'h0,    32'h0,         1, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 'h22, 1, 0, 32'h4,    32'h0,         2, 0, 0, 0, 1, 32'h11220000));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 32'h8,    32'h0,         2, 0, 0, 0, 1, 32'h12345678));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; ld_valid = vecs[i].v; ld_byte = vecs[i].b; ld_last = vecs[i].l;
            mem_ws = vecs[i].ws; addr = vecs[i].addr; wr_data = vecs[i].wd;
            @(posedge clk); #1;
            check($sformatf("v%0d_word_cnt", i), 32'(word_cnt), 32'(vecs[i].cnt));
            check($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d_cpu_rst", i),  32'(cpu_rst),  32'(vecs[i].crst));
            check($sformatf("v%0d_err", i),      32'(err),      32'(vecs[i].err));
            if (vecs[i].chk) check($sformatf("v%0d_data", i), data, vecs[i].data);
        end

        // Core store: old word visible in the store cycle, new word after
        rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        addr = 32'h0000000B; mem_ws = 1'b1; wr_data = 32'hDEADBEEF;
        #4;
        check("store_old", data, 32'h12345678);
        @(posedge clk); #1;
        mem_ws = 1'b0; addr = 32'h8;
        #1;
        check("store_new", data, 32'hDEADBEEF);
        check("store_word_cnt", 32'(word_cnt), 32'd2);

        // Same image with random valid gaps
        img[0] = 8'h20; img[1] = 8'h08; img[2] = 8'h00; img[3] = 8'h05;
        img[4] = 8'h00; img[5] = 8'h00; img[6] = 8'h00; img[7] = 8'h0C;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            int gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                ld_valid = 1'b0; ld_byte = 8'($urandom); ld_last = 1'($urandom);
                @(posedge clk); #1;
            end
            ld_valid = 1'b1; ld_byte = img[k]; ld_last = (k == 7);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        check("gap_word_cnt", 32'(word_cnt), 32'd2);
        check("gap_cpu_rst", 32'(cpu_rst), 32'd0);
        addr = 32'h0; #1; check("gap_mem0", data, 32'h20080005);
        addr = 32'h4; #1; check("gap_mem1", data, 32'h0000000C);
        addr = 32'h8; #1; check("gap_mem2_kept", data, 32'hDEADBEEF);

        // Loader activity in RUN must be ignored
        ld_valid = 1'b1; ld_byte = 8'hFF; ld_last = 1'b0;
        repeat (3) @(posedge clk);
        #1; ld_valid = 1'b0;
        check("run_ld_word_cnt", 32'(word_cnt), 32'd2);
        addr = 32'h0; #1; check("run_ld_mem0", data, 32'h20080005);
        addr = 32'h4; #1; check("run_ld_mem1", data, 32'h0000000C);

        // Overflow on the 4-word instance
        @(posedge clk); #1; ov_rst = 1'b1;
        @(posedge clk); #1;
        check("ov_reset_cnt", 32'(ov_cnt), 32'd0);
        check("ov_reset_err", 32'(ov_err), 32'd0);
        ov_rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            ov_valid = 1'b1; ov_byte = 8'h5A; ov_last = (k == 20);
            @(posedge clk); #1;
            if (k == 4)  check("ov_cnt_b4", 32'(ov_cnt), 32'd1);
            if (k == 16) begin
                check("ov_cnt_b16", 32'(ov_cnt), 32'd4);
                check("ov_err_b16", 32'(ov_err), 32'd0);
            end
            if (k > 16 && k < 20) begin
                check($sformatf("ov_ready_b%0d", k), 32'(ov_ready), 32'd1);
                check($sformatf("ov_err_b%0d", k), 32'(ov_err), 32'd0);
            end
        end
        ov_valid = 1'b0; ov_last = 1'b0;
        check("ov_cnt_b20", 32'(ov_cnt), 32'd4);
        check("ov_err_b20", 32'(ov_err), 32'd1);
        check("ov_ready_b20", 32'(ov_ready), 32'd0);
        check("ov_cpu_rst_b20", 32'(ov_cpu_rst), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ov_err_sticky", 32'(ov_err), 32'd1);
        for (int a = 0; a < 4; a++) begin
            ov_addr = 32'(a * 4); #1;
            check($sformatf("ov_mem%0d", a), ov_data, 32'h5A5A5A5A);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
